// File: rtl/i2c_pkg.sv
// Shared types and encodings for the I2C master sequencer: FSM states,
// bit-time quarters, R/W bit encoding and ACK/NACK SDA levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_WAIT,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_STOP
  } i2c_state_e;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } i2c_quarter_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-bit timer: counts CLK_DIV-1 down to 0 per quarter and steps Q0..Q3.
// With I2C_CLK_STRETCH_EN defined, Q2/Q3 freeze while a slave holds SCL low.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic         HCLK,
  input  logic         HRESET,
  input  logic         clr,
  input  logic         run,
  input  logic         scl_oe,
  input  logic         scl_in,
  output i2c_quarter_e quarter,
  output logic         tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] qcnt;
  logic          frozen;

`ifdef I2C_CLK_STRETCH_EN
  // SCL released by us but still low means the slave is stretching.
  assign frozen = ((quarter == Q2) || (quarter == Q3)) && !scl_oe && !scl_in;
`else
  logic stretch_unused;
  assign stretch_unused = scl_oe ^ scl_in;
  assign frozen         = 1'b0;
`endif

  assign tick = run && !frozen && (qcnt == '0);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      qcnt    <= LOAD;
      quarter <= Q0;
    end else if (clr) begin
      qcnt    <= LOAD;
      quarter <= Q0;
    end else if (run && !frozen) begin
      if (qcnt == '0) begin
        qcnt    <= LOAD;
        quarter <= i2c_quarter_e'(quarter + 2'd1);
      end else begin
        qcnt <= qcnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: START, address byte, N data bytes, STOP with ACK/NAK
// handling. Optional macro I2C_CLK_STRETCH_EN enables slave clock stretching.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV  = 250,
  parameter int NBYTES_W = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                i_start,
  input  logic [6:0]          i_slvaddr,
  input  logic                i_tba,
  input  logic [NBYTES_W-1:0] i_nbytes,
  input  logic [7:0]          i_wdata,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [7:0]          o_rdata,
  output logic                o_rec,
  output logic                o_tra,
  output logic                o_nak,
  output logic                o_busy,
  output logic                o_scl_oe,
  input  logic                i_scl,
  output logic                o_sda_oe,
  input  logic                i_sda,
  output i2c_state_e          o_dbg_state
);

  i2c_state_e          state, state_next;
  i2c_quarter_e        quarter;
  logic                tick, bit_end, smp, accept, scl_lo;
  logic                scl_oe, sda_oe, wr_load, tra, nak;
  logic [7:0]          shift_q, rdata_q;
  logic [2:0]          bitcnt_q;
  logic [NBYTES_W-1:0] rem_q;
  logic                tba_q, ack_q, rec_q;

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .clr     (state == ST_IDLE),
    .run     ((state != ST_IDLE) && (state != ST_WR_WAIT)),
    .scl_oe  (scl_oe),
    .scl_in  (i_scl),
    .quarter (quarter),
    .tick    (tick)
  );

  assign bit_end = tick && (quarter == Q3);
  assign smp     = tick && (quarter == Q2);
  assign accept  = (state == ST_IDLE) && i_start;
  assign scl_lo  = (quarter == Q0) || (quarter == Q1);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (accept) state_next = ST_START;
      ST_START:    if (bit_end) state_next = ST_ADDR;
      ST_ADDR:     if (bit_end && (bitcnt_q == 3'd7)) state_next = ST_ADDR_ACK;
      ST_ADDR_ACK: if (bit_end) begin
        if ((ack_q == SDA_NACK) || (rem_q == '0)) state_next = ST_STOP;
        else if (tba_q == RW_WRITE)               state_next = i_wvalid ? ST_WR_BYTE : ST_WR_WAIT;
        else                                      state_next = ST_RD_BYTE;
      end
      ST_WR_WAIT:  if (i_wvalid) state_next = ST_WR_BYTE;
      ST_WR_BYTE:  if (bit_end && (bitcnt_q == 3'd7)) state_next = ST_WR_ACK;
      ST_WR_ACK:   if (bit_end) begin
        if ((ack_q == SDA_NACK) || (rem_q == NBYTES_W'(1))) state_next = ST_STOP;
        else                                                 state_next = i_wvalid ? ST_WR_BYTE : ST_WR_WAIT;
      end
      ST_RD_BYTE:  if (bit_end && (bitcnt_q == 3'd7)) state_next = ST_RD_ACK;
      ST_RD_ACK:   if (bit_end) state_next = (rem_q != '0) ? ST_RD_BYTE : ST_STOP;
      ST_STOP:     if (bit_end) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Write handshake: i_wdata is taken on any cycle with i_wvalid and o_wready
  // both high; o_wready follows i_wvalid combinationally so a byte that is
  // already waiting at the end of an ACK bit costs no extra bus time.
  always_comb begin
    scl_oe  = 1'b0;
    sda_oe  = 1'b0;
    wr_load = (state_next == ST_WR_BYTE) && (state != ST_WR_BYTE);
    tra     = (state == ST_WR_ACK) && bit_end && (ack_q == SDA_ACK);
    nak     = ((state == ST_ADDR_ACK) || (state == ST_WR_ACK)) && bit_end && (ack_q == SDA_NACK);
    case (state)
      ST_START:    sda_oe = (quarter == Q2) || (quarter == Q3);
      ST_ADDR, ST_WR_BYTE: begin
        scl_oe = scl_lo;
        sda_oe = ~shift_q[7];
      end
      ST_ADDR_ACK, ST_WR_ACK, ST_RD_BYTE: scl_oe = scl_lo;
      ST_RD_ACK: begin
        scl_oe = scl_lo;
        sda_oe = (rem_q != '0);
      end
      ST_WR_WAIT:  scl_oe = 1'b1;
      ST_STOP: begin
        scl_oe = (quarter == Q0);
        sda_oe = (quarter != Q3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      shift_q  <= 8'h00;
      rdata_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      rem_q    <= '0;
      tba_q    <= 1'b0;
      ack_q    <= 1'b0;
      rec_q    <= 1'b0;
    end else begin
      rec_q <= 1'b0;
      if (accept) begin
        shift_q  <= {i_slvaddr, i_tba};
        tba_q    <= i_tba;
        rem_q    <= i_nbytes;
        bitcnt_q <= 3'd0;
      end else if (wr_load) begin
        shift_q <= i_wdata;
      end else if (((state == ST_ADDR) || (state == ST_WR_BYTE)) && bit_end) begin
        shift_q <= {shift_q[6:0], 1'b0};
      end else if ((state == ST_RD_BYTE) && smp) begin
        shift_q <= {shift_q[6:0], i_sda};
      end
      if (((state == ST_ADDR) || (state == ST_WR_BYTE) || (state == ST_RD_BYTE)) && bit_end)
        bitcnt_q <= bitcnt_q + 3'd1;
      if ((state == ST_RD_BYTE) && smp && (bitcnt_q == 3'd7)) begin
        rdata_q <= {shift_q[6:0], i_sda};
        rec_q   <= 1'b1;
      end
      // Remaining count drops once a read byte completes, so RD_ACK sees what is left.
      if (((state == ST_RD_BYTE) && bit_end && (bitcnt_q == 3'd7)) || tra)
        rem_q <= rem_q - NBYTES_W'(1);
      if (((state == ST_ADDR_ACK) || (state == ST_WR_ACK)) && smp)
        ack_q <= i_sda;
    end
  end

  assign o_wready    = wr_load;
  assign o_tra       = tra;
  assign o_nak       = nak;
  assign o_rec       = rec_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = (state != ST_IDLE);
  assign o_scl_oe    = scl_oe;
  assign o_sda_oe    = sda_oe;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a bit-level I2C slave model.
// The stretch case runs only when I2C_CLK_STRETCH_EN is defined.
module tb_i2c_master_ctrl;
  import i2c_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int BIT_T   = 4 * CLK_DIV;

  logic       HCLK, HRESET;
  logic       i_start, i_tba, i_wvalid;
  logic [6:0] i_slvaddr;
  logic [7:0] i_nbytes, i_wdata;
  logic       o_wready, o_rec, o_tra, o_nak, o_busy, o_scl_oe, o_sda_oe;
  logic [7:0] o_rdata;
  i2c_state_e o_dbg_state;
  logic       bus_scl, bus_sda;

  // Bench-side controls (each written by the main sequence only)
  logic       addr_nak, wv_hold, stretch;
  logic [7:0] wtab[4];
  logic [7:0] rd_tab[2];
  int         w_n;
  int         clr_gen = 0;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] bus_q[$];
  logic       mack_q[$];
  logic [7:0] rdq[$];
  int busy_cyc, wready_n, tra_n, nak_n, rec_n;

  assign bus_scl = !o_scl_oe && !stretch;
  assign bus_sda = !o_sda_oe && !slv_low;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .NBYTES_W(8)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .i_start     (i_start),
    .i_slvaddr   (i_slvaddr),
    .i_tba       (i_tba),
    .i_nbytes    (i_nbytes),
    .i_wdata     (i_wdata),
    .i_wvalid    (i_wvalid),
    .o_wready    (o_wready),
    .o_rdata     (o_rdata),
    .o_rec       (o_rec),
    .o_tra       (o_tra),
    .o_nak       (o_nak),
    .o_busy      (o_busy),
    .o_scl_oe    (o_scl_oe),
    .i_scl       (bus_scl),
    .o_sda_oe    (o_sda_oe),
    .i_sda       (bus_sda),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_bus(input string tag);
    check_eq({tag, "_nbytes"}, bus_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), bus_q[i], exp_q[i]);
  endtask

  // ---------------- write-data driver ----------------
  int   w_idx = 0;
  int   drv_seen = 0;
  logic took;
  initial begin
    i_wvalid = 1'b0;
    i_wdata  = 8'h00;
    forever begin
      @(negedge HCLK);
      took = o_wready;
      @(posedge HCLK);
      #1;
      if (clr_gen != drv_seen) begin
        drv_seen = clr_gen;
        w_idx    = 0;
      end else if (took) begin
        w_idx++;
      end
      if (w_idx < w_n && !wv_hold) begin
        i_wvalid = 1'b1;
        i_wdata  = wtab[w_idx];
      end else begin
        i_wvalid = 1'b0;
        i_wdata  = 8'h00;
      end
    end
  end

  // ---------------- pulse / busy monitor ----------------
  int mon_seen = 0;
  initial begin
    busy_cyc = 0; wready_n = 0; tra_n = 0; nak_n = 0; rec_n = 0;
    forever begin
      @(negedge HCLK);
      if (clr_gen != mon_seen) begin
        mon_seen = clr_gen;
        busy_cyc = 0; wready_n = 0; tra_n = 0; nak_n = 0; rec_n = 0;
        rdq.delete();
      end
      if (o_busy)   busy_cyc++;
      if (o_wready) wready_n++;
      if (o_tra)    tra_n++;
      if (o_nak)    nak_n++;
      if (o_rec) begin
        rec_n++;
        rdq.push_back(o_rdata);
      end
    end
  end

  // ---------------- slave model ----------------
  logic       slv_low;
  logic       prev_scl, prev_sda, is_read, done, nak_seen;
  logic [7:0] rx, cur;
  int         bitpos, byte_idx;
  int         slv_seen = 0;
  initial begin
    slv_low = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
    is_read = 1'b0; done = 1'b1; nak_seen = 1'b0;
    rx = 8'h00; cur = 8'h00; bitpos = 0; byte_idx = 0;
    forever begin
      @(negedge HCLK);
      if (clr_gen != slv_seen) begin
        slv_seen = clr_gen;
        bus_q.delete();
        mack_q.delete();
      end
      if (HRESET) begin
        slv_low = 1'b0;
        done    = 1'b1;
        bitpos  = 0;
      end else if (prev_scl && bus_scl && prev_sda && !bus_sda) begin
        bitpos = 0; byte_idx = 0; done = 1'b0; nak_seen = 1'b0; slv_low = 1'b0;
      end else if (prev_scl && bus_scl && !prev_sda && bus_sda) begin
        done = 1'b1; slv_low = 1'b0;
      end else if (!done && !prev_scl && bus_scl) begin
        if (bitpos < 8) begin
          rx = {rx[6:0], bus_sda};
        end else begin
          if (byte_idx > 0 && is_read) mack_q.push_back(bus_sda);
          if (bus_sda) nak_seen = 1'b1;
        end
        bitpos++;
        if (bitpos == 8) begin
          bus_q.push_back(rx);
          if (byte_idx == 0) is_read = rx[0];
        end
      end else if (!done && prev_scl && !bus_scl) begin
        if (bitpos == 8) begin
          slv_low = (byte_idx == 0) ? !addr_nak : !is_read;
        end else if (bitpos == 9) begin
          bitpos = 0;
          byte_idx++;
          if (nak_seen) begin
            done = 1'b1; slv_low = 1'b0;
          end else if (is_read && byte_idx <= 2) begin
            cur     = rd_tab[byte_idx-1];
            slv_low = !cur[7];
          end else begin
            slv_low = 1'b0;
          end
        end else if (is_read && byte_idx > 0) begin
          slv_low = !cur[7-bitpos];
        end else begin
          slv_low = 1'b0;
        end
      end
      prev_scl = bus_scl;
      prev_sda = bus_sda;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic new_test();
    clr_gen++;
    @(posedge HCLK);
    #2;
    exp_q.delete();
  endtask

  task automatic start_xfer(input logic [6:0] addr, input logic tba, input logic [7:0] n);
    i_slvaddr = addr;
    i_tba     = tba;
    i_nbytes  = n;
    i_start   = 1'b1;
    @(posedge HCLK);
    #2;
    i_start   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (o_busy && n < limit) begin
      @(posedge HCLK);
      #2;
      n++;
    end
    check_eq({tag, "_idle"}, o_busy, 1'b0);
    repeat (2) @(posedge HCLK);
    #2;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, low_cnt;
    HRESET = 1'b1; i_start = 1'b0; i_slvaddr = 7'h00; i_tba = 1'b0; i_nbytes = 8'h00;
    addr_nak = 1'b0; wv_hold = 1'b0; stretch = 1'b0; w_n = 0;
    for (int i = 0; i < 4; i++) wtab[i] = 8'h00;
    rd_tab[0] = 8'h81; rd_tab[1] = 8'h7E;
    repeat (3) @(posedge HCLK);
    #2;

    // Reset state
    check_eq("rst_busy",   o_busy,   1'b0);
    check_eq("rst_scl_oe", o_scl_oe, 1'b0);
    check_eq("rst_sda_oe", o_sda_oe, 1'b0);
    check_eq("rst_wready", o_wready, 1'b0);
    check_eq("rst_tra",    o_tra,    1'b0);
    check_eq("rst_nak",    o_nak,    1'b0);
    check_eq("rst_rec",    o_rec,    1'b0);
    check_eq("rst_rdata",  o_rdata,  8'h00);
    HRESET = 1'b0;
    @(posedge HCLK);
    #2;

    // Write 0xA5, 0x3C to 0x50, all ACKed
    wtab[0] = 8'hA5; wtab[1] = 8'h3C; w_n = 2;
    new_test();
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    start_xfer(7'h50, RW_WRITE, 8'd2);
    wait_idle("wr", 2000);
    check_bus("wr_bus");
    check_eq("wr_wready", wready_n, 2);
    check_eq("wr_tra",    tra_n,    2);
    check_eq("wr_nak",    nak_n,    0);
    check_eq("wr_busy",   busy_cyc, 464);

    // Address NAK: no data consumed, STOP after the address byte
    addr_nak = 1'b1;
    new_test();
    exp_q.push_back(8'hA0);
    start_xfer(7'h50, RW_WRITE, 8'd2);
    wait_idle("nak", 2000);
    check_bus("nak_bus");
    check_eq("nak_nak",    nak_n,    1);
    check_eq("nak_wready", wready_n, 0);
    check_eq("nak_tra",    tra_n,    0);
    check_eq("nak_busy",   busy_cyc, 11 * BIT_T);
    addr_nak = 1'b0;

    // Read two bytes 0x81, 0x7E: master ACKs the first and NACKs the second
    w_n = 0;
    new_test();
    exp_q.push_back(8'hA1); exp_q.push_back(8'h81); exp_q.push_back(8'h7E);
    start_xfer(7'h50, RW_READ, 8'd2);
    wait_idle("rd", 2000);
    check_bus("rd_bus");
    check_eq("rd_rec",  rec_n, 2);
    check_eq("rd_nrx",  rdq.size(), 2);
    if (rdq.size() == 2) begin
      check_eq("rd_data0", rdq[0], 8'h81);
      check_eq("rd_data1", rdq[1], 8'h7E);
    end
    check_eq("rd_nmack", mack_q.size(), 2);
    if (mack_q.size() == 2) begin
      check_eq("rd_mack0", mack_q[0], SDA_ACK);
      check_eq("rd_mack1", mack_q[1], SDA_NACK);
    end
    check_eq("rd_busy",  busy_cyc, 464);
    check_eq("rd_rdata", o_rdata,  8'h7E);

    // i_wvalid held low in WR_WAIT: SCL must stay pulled low
    wtab[0] = 8'h5A; w_n = 1; wv_hold = 1'b1;
    new_test();
    exp_q.push_back(8'hA0); exp_q.push_back(8'h5A);
    start_xfer(7'h50, RW_WRITE, 8'd1);
    n = 0;
    while (o_dbg_state != ST_WR_WAIT && n < 1000) begin
      @(posedge HCLK);
      #2;
      n++;
    end
    check_eq("stall_state", o_dbg_state, ST_WR_WAIT);
    low_cnt = 0;
    repeat (100) begin
      @(negedge HCLK);
      if (o_scl_oe) low_cnt++;
    end
    check_eq("stall_scl_low", low_cnt, 100);
    @(posedge HCLK);
    #2;
    wv_hold = 1'b0;
    wait_idle("stall", 3000);
    check_bus("stall_bus");
    check_eq("stall_tra",    tra_n,    1);
    check_eq("stall_wready", wready_n, 1);

    // Reset mid address byte, then a normal one-byte write
    wtab[0] = 8'h11; w_n = 1;
    new_test();
    start_xfer(7'h50, RW_WRITE, 8'd1);
    repeat (40) @(posedge HCLK);
    n = 0;
    while (!o_scl_oe && n < 40) begin
      @(posedge HCLK);
      n++;
    end
    #2;
    HRESET = 1'b1;
    #1;
    check_eq("mrst_scl_oe", o_scl_oe, 1'b0);
    check_eq("mrst_sda_oe", o_sda_oe, 1'b0);
    check_eq("mrst_busy",   o_busy,   1'b0);
    repeat (3) @(posedge HCLK);
    #2;
    HRESET = 1'b0;
    wtab[0] = 8'h3C; w_n = 1;
    new_test();
    exp_q.push_back(8'hA0); exp_q.push_back(8'h3C);
    start_xfer(7'h50, RW_WRITE, 8'd1);
    wait_idle("post", 2000);
    check_bus("post_bus");
    check_eq("post_tra",  tra_n,    1);
    check_eq("post_busy", busy_cyc, 20 * BIT_T);

`ifdef I2C_CLK_STRETCH_EN
    // Slave stretches SCL for 50 HCLK in Q2 of the first data bit
    wtab[0] = 8'hA5; wtab[1] = 8'h3C; w_n = 2;
    new_test();
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    start_xfer(7'h50, RW_WRITE, 8'd2);
    n = 0;
    while (!(o_dbg_state == ST_WR_BYTE && !o_scl_oe) && n < 2000) begin
      @(negedge HCLK);
      n++;
    end
    check_eq("str_reach", o_dbg_state, ST_WR_BYTE);
    stretch = 1'b1;
    repeat (50) @(negedge HCLK);
    stretch = 1'b0;
    @(posedge HCLK);
    #2;
    wait_idle("str", 2000);
    check_bus("str_bus");
    check_eq("str_tra",  tra_n,    2);
    check_eq("str_busy", busy_cyc, 464 + 50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Byte-level I2C master sequencer that drives the bus on behalf of the APB register bank. It takes the slave address and R/W bit from the register bank and runs START, address byte, N data bytes and STOP, with ACK/NAK handling. It returns per-byte status pulses (transmitted, received, NAK) to the register bank's status register. It sits between the register bank and the open-drain SCL/SDA pads.

## Interface
- CLK_DIV, 250: HCLK cycles per quarter SCL period; minimum 2.
- NBYTES_W, 8: width of the byte-count field.
- HCLK  in  1  system clock; all logic on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle transfer request; ignored while o_busy=1.
- i_slvaddr  in  7  slave address; latched on accepted i_start.
- i_tba  in  1  R/W bit of the address byte (0 write, 1 read); latched on accepted i_start.
- i_nbytes  in  NBYTES_W  data bytes to transfer after the address; 0 means address only. Latched on accepted i_start.
- i_wdata  in  8  write byte.
- i_wvalid  in  1  i_wdata valid.
- o_wready  out  1  one-cycle pulse; i_wdata consumed this cycle.
- o_rdata  out  8  last received byte; held until the next receive.
- o_rec  out  1  one-cycle pulse; o_rdata updated this cycle.
- o_tra  out  1  one-cycle pulse; a data byte was sent and ACKed.
- o_nak  out  1  one-cycle pulse; NAK seen on the address or a write byte.
- o_busy  out  1  high from the accepted i_start until STOP completes.
- o_scl_oe  out  1  1 pulls SCL low; 0 releases it.
- i_scl  in  1  sampled SCL pad.
- o_sda_oe  out  1  1 pulls SDA low; 0 releases it.
- i_sda  in  1  sampled SDA pad; externally synchronised.

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, WR_WAIT, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP.
- Bit time is 4 quarters, Q0 to Q3:
  - SCL is low in Q0–Q1 and released in Q2–Q3.
  - SDA changes only at the start of Q0.
  - SDA is sampled on the last HCLK of Q2.
- IDLE: both lines released. An accepted i_start latches the inputs, sets o_busy and goes to START.
- START (1 bit time): SDA released Q0–Q1 and pulled low Q2–Q3, with SCL released throughout. Then ADDR.
- ADDR: shift {slvaddr, tba} out MSB first, 8 bits. ADDR_ACK releases SDA and samples it.
  - SDA=1: pulse o_nak, go to STOP.
  - SDA=0 and nbytes=0: go to STOP.
  - SDA=0 and tba=0: go to WR_WAIT.
  - SDA=0 and tba=1: go to RD_BYTE.
- WR_WAIT: SCL held low. When i_wvalid=1, pulse o_wready in the same cycle, load the shifter and go to WR_BYTE.
- WR_ACK samples SDA.
  - NAK: pulse o_nak, go to STOP; remaining bytes are dropped.
  - ACK: pulse o_tra and decrement the remaining count. Go to STOP if it reaches 0, else WR_WAIT.
- RD_BYTE: shift in 8 bits MSB first. Update o_rdata and pulse o_rec on the cycle after the 8th sample.
- RD_ACK: drive ACK (SDA low) if more bytes remain, else NACK (SDA released). Then RD_BYTE or STOP.
- STOP (1 bit time): SDA low Q0–Q2, SCL released from Q1, SDA released at Q3. Then IDLE; o_busy clears on entry to IDLE.
- Simultaneous i_start and STOP completion: i_start is ignored.
- Arbitration loss and repeated START are not supported.

## Timing
- Reset: all outputs are 0, the FSM is in IDLE, and both lines are released. Reset takes effect immediately when HRESET asserts, including mid-transfer; no STOP is generated.
- Accepted i_start to START Q0: 1 HCLK.
- Transfer length without stalls or stretching: (2 + 9·(1+nbytes)) · 4 · CLK_DIV HCLK cycles.
- Pulses o_tra, o_nak and o_rec each last exactly 1 HCLK.
- Quarter counter: counts CLK_DIV−1 down to 0. Counting down 0 → CLK_DIV−1 advances the quarter, wrapping Q3 → Q0.

## Configuration
- I2C_CLK_STRETCH_EN defined: in Q2 and Q3 the quarter counter freezes while o_scl_oe=0 and i_scl=0. The slave may stretch indefinitely.
- I2C_CLK_STRETCH_EN undefined: i_scl is unused and timing is purely counter-based.

## Structure
- Package i2c_pkg holds:
  - the state enum and quarter enum;
  - the R/W encoding constants;
  - the ACK/NACK level constants.
- Sub-module i2c_bit_timer holds the quarter counter and quarter index, and implements the stretch freeze. Its outputs are quarter and tick.

## Test plan
- CLK_DIV=4, i_slvaddr=0x50, i_tba=0, i_nbytes=2, write data 0xA5 then 0x3C, slave ACKs every byte:
  - bus carries bytes 0xA0, 0xA5, 0x3C;
  - o_wready ×2 and o_tra ×2;
  - o_busy high for exactly 464 HCLK.
- Same address but the slave leaves SDA high in ADDR_ACK:
  - o_nak ×1, no o_wready, STOP follows;
  - o_busy high for 11 bit times.
- i_tba=1, i_nbytes=2, slave returns 0x81 then 0x7E:
  - o_rec ×2 with o_rdata 0x81 then 0x7E;
  - master ACKs the first byte and NACKs the second.
- Hold i_wvalid low for 100 HCLK in WR_WAIT: SCL stays low; the transfer resumes correctly once i_wvalid rises.
- Assert HRESET mid-byte: o_scl_oe=0, o_sda_oe=0 and o_busy=0 immediately; a subsequent i_start works normally.
- With I2C_CLK_STRETCH_EN, slave holds SCL low for 50 HCLK in Q2 of a data bit: the bit is lengthened by 50 HCLK and the data is still correct.
